bomb_countdown: RTL and testbench
=================================

Name: bomb_countdown

Overview:
- Game-level countdown timer that consumes the slow divided clock produced by the clock divider (clk_o, ~clk/102) as a tick source.
- Edge-detects the tick in the system clock domain, prescales ticks to seconds and counts an mm:ss BCD value down to 00:00.
- Supports pause, time penalties and defusal, and drives the 7-seg decoders and the game controller FSM.

Parameters:
- TICKS_PER_SEC, 10, tick rising edges per second (>=1)
- INIT_MIN, 5, minutes loaded on reset/load (0..99)
- INIT_SEC, 0, seconds loaded on reset/load (0..59); INIT_MIN:INIT_SEC must be nonzero
- PENALTY_SEC, 10, seconds removed per penalty pulse (1..59)
- WARN_SEC, 10, warn asserted when remaining <= this (1..59)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- tick_i  in  1  divided clock from divider, level signal, synchronous to clk
- load  in  1  pulse: reload INIT time, go IDLE
- start  in  1  pulse: begin/resume countdown
- pause  in  1  pulse: freeze countdown
- penalty  in  1  pulse: subtract PENALTY_SEC
- defuse  in  1  pulse: bomb defused
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD remaining time
- state_o  out  3  0 IDLE, 1 RUN, 2 PAUSE, 3 DEFUSED, 4 EXPLODED
- warn  out  1  low-time warning level
- boom  out  1  one-cycle pulse on entry to EXPLODED

Behaviour:
- One clock; all registers update on posedge clk only; rst synchronous, active-high, highest priority.
- Reset values: time = INIT_MIN:INIT_SEC, state IDLE, prescaler 0, boom 0, warn 0, tick_d = 1.
  - tick_d = 1 because the divider resets with its output high; this prevents a false edge after reset.
- Edge detect: tick_edge = tick_i & ~tick_d, where tick_d is tick_i registered. A tick_i rise sampled at edge k updates time at that same edge k, so new outputs are visible after edge k: 1-cycle latency from tick_i rise.
- Prescaler: counts tick_edge only in RUN.
  - On tick_edge with prescaler == TICKS_PER_SEC-1: prescaler -> 0 and one second is decremented.
  - Cleared on load, and on start from IDLE. Held (not cleared) on PAUSE.
- BCD decrement with borrow:
  - sec_ones 0 -> 9 with borrow from sec_tens.
  - sec_tens 0 -> 5 with borrow from minutes.
  - Minutes borrow likewise (min_ones 0 -> 9, min_tens decrements).
  - Digits never leave their legal range.
- Penalty (RUN or PAUSE only; ignored elsewhere):
  - Remaining -= PENALTY_SEC, saturating at 00:00.
  - If a second decrement occurs in the same cycle, both apply (PENALTY_SEC+1 total).
- Expiry: any update that results in 00:00 while in RUN or PAUSE -> EXPLODED at that edge, boom = 1 for exactly that cycle.
- FSM input priority within a cycle: load > defuse > pause > start > penalty/tick.
  - IDLE: load -> reload, stay IDLE; start -> RUN (ignored if time is 00:00).
  - RUN: load -> IDLE+reload; defuse -> DEFUSED; pause -> PAUSE; expiry -> EXPLODED.
  - PAUSE: load -> IDLE+reload; defuse -> DEFUSED; start -> RUN; penalty expiry -> EXPLODED. Ticks are ignored.
  - DEFUSED, EXPLODED: only load (-> IDLE+reload) or rst leaves. Time is frozen; all other inputs are ignored.
- Defuse in the same cycle as expiry -> DEFUSED, boom stays 0, time shows the pre-update value.
- warn = (state RUN or PAUSE) and 0 < remaining <= WARN_SEC. Registered; tracks time with the same 1-cycle latency.
- rst mid-RUN -> all reset values at the next edge; a pending tick edge is discarded.

Test Plan:
- Assert rst 2 cycles with tick_i high -> 05:00, state 0, boom 0, warn 0; no decrement on the first tick_i cycle after reset release.
- TICKS_PER_SEC=2, INIT 01:00: start, 2 tick_i rising edges -> 00:59 one cycle after the 2nd rise; 60 more edges -> 00:29.
- INIT 00:03, TICKS_PER_SEC=1: start, 3 rises -> 00:00, state 4, boom high exactly 1 cycle; further ticks, start, penalty -> no change; load -> 00:03, IDLE.
- In RUN at 00:25: penalty -> 00:15. At 00:07: penalty -> 00:00, EXPLODED, boom. Penalty coinciding with a second decrement at 00:25 -> 00:14.
- At 00:10 (WARN_SEC=10): warn=1; pause -> 20 ticks, time and prescaler hold; start -> resumes; next decrement after the remaining prescaler count.
- At 00:01 with final tick edge and defuse in the same cycle -> DEFUSED, 00:01, boom 0. rst asserted mid-RUN -> 05:00 IDLE next edge.

Source files
------------

// File: rtl/bomb_countdown_if.sv
// Control and display bundle of the bomb countdown timer.
// The game side (master) drives tick and command pulses; the timer (slave) returns time and status.
interface bomb_countdown_if;
    logic       tick_i;
    logic       load;
    logic       start;
    logic       pause;
    logic       penalty;
    logic       defuse;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] state_o;
    logic       warn;
    logic       boom;

    modport master (
        output tick_i, load, start, pause, penalty, defuse,
        input  min_tens, min_ones, sec_tens, sec_ones, state_o, warn, boom
    );

    modport slave (
        input  tick_i, load, start, pause, penalty, defuse,
        output min_tens, min_ones, sec_tens, sec_ones, state_o, warn, boom
    );
endinterface

// File: rtl/bomb_countdown.sv
// mm:ss BCD countdown driven by edges of the divided tick clock, with pause,
// time penalties, defusal and a one-cycle explosion pulse.
module bomb_countdown #(
    parameter int TICKS_PER_SEC = 10,
    parameter int INIT_MIN      = 5,
    parameter int INIT_SEC      = 0,
    parameter int PENALTY_SEC   = 10,
    parameter int WARN_SEC      = 10
) (
    input  logic clk,
    input  logic rst,
    bomb_countdown_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_PAUSE    = 3'd2,
        ST_DEFUSED  = 3'd3,
        ST_EXPLODED = 3'd4
    } state_t;

    localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRE_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [15:0]     INIT_TIME = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                             4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};
    localparam logic [5:0]      PEN_AMT   = 6'(PENALTY_SEC);
    localparam logic [12:0]     WARN_LIM  = 13'(WARN_SEC);

    // Packed time layout: {min_tens, min_ones, sec_tens, sec_ones}
    state_t         state_r;
    state_t         state_n_s;
    logic [15:0]    time_r;
    logic [15:0]    time_n_s;
    logic [15:0]    upd_s;
    logic [PW-1:0]  pre_r;
    logic [PW-1:0]  pre_n_s;
    logic           tick_d_r;
    logic           tick_edge_s;
    logic           boom_r;
    logic           boom_n_s;
    logic           warn_r;
    logic           warn_n_s;
    logic [5:0]     amt_s;
    logic           step_s;

    function automatic logic [12:0] to_secs(input logic [15:0] t);
        return 13'(t[15:12]) * 13'd600 + 13'(t[11:8]) * 13'd60
             + 13'(t[7:4]) * 13'd10 + 13'(t[3:0]);
    endfunction

    // Digit-wise subtraction of amt (<= 60 s); caller guarantees the result is positive.
    function automatic logic [15:0] bcd_sub(input logic [15:0] t, input logic [5:0] amt);
        logic [3:0] a_t;
        logic [3:0] a_o;
        logic [3:0] need;
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        logic       b1;
        logic       b2;
        a_t = 4'(amt / 6'd10);
        a_o = 4'(amt % 6'd10);
        mt  = t[15:12];
        mo  = t[11:8];
        st  = t[7:4];
        so  = t[3:0];
        if (so >= a_o) begin
            so = so - a_o;
            b1 = 1'b0;
        end else begin
            so = so + 4'd10 - a_o;
            b1 = 1'b1;
        end
        need = a_t + {3'd0, b1};
        if (st >= need) begin
            st = st - need;
            b2 = 1'b0;
        end else begin
            st = st + 4'd6 - need;
            b2 = 1'b1;
        end
        if (b2) begin
            if (mo == 4'd0) begin
                mo = 4'd9;
                mt = mt - 4'd1;
            end else begin
                mo = mo - 4'd1;
            end
        end else begin
            mo = mo;
        end
        return {mt, mo, st, so};
    endfunction

    // Next-state, time update, prescaler and status decode
    always_comb begin
        tick_edge_s = bus.tick_i & ~tick_d_r;
        state_n_s   = state_r;
        time_n_s    = time_r;
        pre_n_s     = pre_r;
        boom_n_s    = 1'b0;
        amt_s       = 6'd0;
        step_s      = 1'b0;
        upd_s       = time_r;
        warn_n_s    = 1'b0;

        if (bus.load) begin
            state_n_s = ST_IDLE;
            time_n_s  = INIT_TIME;
            pre_n_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && (time_r != 16'd0)) begin
                        state_n_s = ST_RUN;
                        pre_n_s   = '0;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.defuse) begin
                        state_n_s = ST_DEFUSED;
                    end else if (bus.pause) begin
                        state_n_s = ST_PAUSE;
                    end else begin
                        step_s = 1'b1;
                        if (tick_edge_s) begin
                            if (pre_r == PRE_MAX) begin
                                pre_n_s = '0;
                                amt_s   = 6'd1;
                            end else begin
                                pre_n_s = pre_r + PW'(1);
                            end
                        end else begin
                            pre_n_s = pre_r;
                        end
                        if (bus.penalty) begin
                            amt_s = amt_s + PEN_AMT;
                        end else begin
                            amt_s = amt_s;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.defuse) begin
                        state_n_s = ST_DEFUSED;
                    end else if (bus.start) begin
                        state_n_s = ST_RUN;
                    end else if (bus.penalty) begin
                        step_s = 1'b1;
                        amt_s  = PEN_AMT;
                    end else begin
                        state_n_s = ST_PAUSE;
                    end
                end
                ST_DEFUSED, ST_EXPLODED: begin
                    state_n_s = state_r;
                end
                default: begin
                    state_n_s = ST_IDLE;
                    time_n_s  = INIT_TIME;
                    pre_n_s   = '0;
                end
            endcase
        end

        // Saturate at 00:00 instead of letting the minutes underflow
        if (amt_s == 6'd0) begin
            upd_s = time_r;
        end else if (to_secs(time_r) <= 13'(amt_s)) begin
            upd_s = 16'd0;
        end else begin
            upd_s = bcd_sub(time_r, amt_s);
        end

        if (step_s) begin
            time_n_s = upd_s;
            if (upd_s == 16'd0) begin
                state_n_s = ST_EXPLODED;
                boom_n_s  = 1'b1;
            end else begin
                boom_n_s  = 1'b0;
            end
        end else begin
            time_n_s = time_n_s;
        end

        if (((state_n_s == ST_RUN) || (state_n_s == ST_PAUSE)) && (time_n_s != 16'd0)
            && (to_secs(time_n_s) <= WARN_LIM)) begin
            warn_n_s = 1'b1;
        end else begin
            warn_n_s = 1'b0;
        end
    end

    // State, time and status registers; tick history resets high to mask a false edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            time_r   <= INIT_TIME;
            pre_r    <= '0;
            tick_d_r <= 1'b1;
            boom_r   <= 1'b0;
            warn_r   <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            time_r   <= time_n_s;
            pre_r    <= pre_n_s;
            tick_d_r <= bus.tick_i;
            boom_r   <= boom_n_s;
            warn_r   <= warn_n_s;
        end
    end

    assign bus.min_tens = time_r[15:12];
    assign bus.min_ones = time_r[11:8];
    assign bus.sec_tens = time_r[7:4];
    assign bus.sec_ones = time_r[3:0];
    assign bus.state_o  = state_r;
    assign bus.warn     = warn_r;
    assign bus.boom     = boom_r;

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed bench for bomb_countdown: four instances with different tick rates
// and start times, driven on the falling edge and checked on the falling edge.
module tb_bomb_countdown;

    localparam int TPS  [4] = '{10, 2, 1, 1};
    localparam int IMIN [4] = '{5, 1, 0, 0};
    localparam int ISEC [4] = '{0, 0, 3, 25};

    localparam logic [5:0] M_TICK  = 6'b100000;
    localparam logic [5:0] M_LOAD  = 6'b010000;
    localparam logic [5:0] M_START = 6'b001000;
    localparam logic [5:0] M_PAUSE = 6'b000100;
    localparam logic [5:0] M_PEN   = 6'b000010;
    localparam logic [5:0] M_DEF   = 6'b000001;

    logic             clk;
    logic             rst;
    logic [3:0]       tick_v;
    logic [3:0]       load_v;
    logic [3:0]       start_v;
    logic [3:0]       pause_v;
    logic [3:0]       pen_v;
    logic [3:0]       def_v;
    logic [3:0][15:0] tm;
    logic [3:0][2:0]  st;
    logic [3:0]       warn_v;
    logic [3:0]       boom_v;

    int n_cmp;
    int n_err;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bomb_countdown_if bus ();
        assign bus.tick_i  = tick_v[g];
        assign bus.load    = load_v[g];
        assign bus.start   = start_v[g];
        assign bus.pause   = pause_v[g];
        assign bus.penalty = pen_v[g];
        assign bus.defuse  = def_v[g];
        assign tm[g]       = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
        assign st[g]       = bus.state_o;
        assign warn_v[g]   = bus.warn;
        assign boom_v[g]   = bus.boom;

        bomb_countdown #(
            .TICKS_PER_SEC (TPS[g]),
            .INIT_MIN      (IMIN[g]),
            .INIT_SEC      (ISEC[g]),
            .PENALTY_SEC   (10),
            .WARN_SEC      (10)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle pulse of the selected inputs; tick is released afterwards only if it was pulsed
    task automatic drive(input int i, input logic [5:0] m);
        if (m[5]) tick_v[i] = 1'b1;
        load_v[i]  = m[4];
        start_v[i] = m[3];
        pause_v[i] = m[2];
        pen_v[i]   = m[1];
        def_v[i]   = m[0];
        @(negedge clk);
        if (m[5]) tick_v[i] = 1'b0;
        load_v[i]  = 1'b0;
        start_v[i] = 1'b0;
        pause_v[i] = 1'b0;
        pen_v[i]   = 1'b0;
        def_v[i]   = 1'b0;
    endtask

    task automatic do_ticks(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            tick_v[i] = 1'b1;
            @(negedge clk);
            tick_v[i] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        tick_v  = 4'hF;
        load_v  = 4'h0;
        start_v = 4'h0;
        pause_v = 4'h0;
        pen_v   = 4'h0;
        def_v   = 4'h0;

        repeat (2) @(negedge clk);
        chk("rst_time",  tm[0], 16'h0500);
        chk("rst_state", {13'd0, st[0]}, 16'd0);
        chk("rst_boom",  {15'd0, boom_v[0]}, 16'd0);
        chk("rst_warn",  {15'd0, warn_v[0]}, 16'd0);
        chk("rst_time_c", tm[2], 16'h0003);
        rst = 1'b0;

        // Start with tick still high: the held level must not count as an edge
        drive(0, M_START);
        drive(2, M_START);
        chk("run_state_a", {13'd0, st[0]}, 16'd1);
        @(negedge clk);
        chk("no_false_edge", tm[2], 16'h0003);
        tick_v = 4'h0;
        @(negedge clk);
        chk("no_false_edge2", tm[2], 16'h0003);

        // TICKS_PER_SEC=2, 01:00
        drive(1, M_START);
        do_ticks(1, 1);
        chk("b_first_tick", tm[1], 16'h0100);
        tick_v[1] = 1'b1;
        @(negedge clk);
        chk("b_borrow_min", tm[1], 16'h0059);
        tick_v[1] = 1'b0;
        @(negedge clk);
        do_ticks(1, 60);
        chk("b_60_edges", tm[1], 16'h0029);
        chk("b_warn_off", {15'd0, warn_v[1]}, 16'd0);

        // TICKS_PER_SEC=1, 00:03 expiry
        do_ticks(2, 2);
        chk("c_0001", tm[2], 16'h0001);
        chk("c_warn", {15'd0, warn_v[2]}, 16'd1);
        drive(2, M_TICK);
        chk("c_zero", tm[2], 16'h0000);
        chk("c_expl", {13'd0, st[2]}, 16'd4);
        chk("c_boom", {15'd0, boom_v[2]}, 16'd1);
        chk("c_warn_expl", {15'd0, warn_v[2]}, 16'd0);
        @(negedge clk);
        chk("c_boom_1cyc", {15'd0, boom_v[2]}, 16'd0);
        drive(2, M_TICK | M_START | M_PEN);
        chk("c_frozen_t", tm[2], 16'h0000);
        chk("c_frozen_s", {13'd0, st[2]}, 16'd4);
        chk("c_frozen_b", {15'd0, boom_v[2]}, 16'd0);
        @(negedge clk);
        drive(2, M_LOAD);
        chk("c_load_t", tm[2], 16'h0003);
        chk("c_load_s", {13'd0, st[2]}, 16'd0);

        // Defuse coinciding with the final tick
        drive(2, M_START);
        do_ticks(2, 2);
        drive(2, M_TICK | M_DEF);
        chk("c_def_s", {13'd0, st[2]}, 16'd3);
        chk("c_def_t", tm[2], 16'h0001);
        chk("c_def_b", {15'd0, boom_v[2]}, 16'd0);
        @(negedge clk);
        chk("c_def_b2", {15'd0, boom_v[2]}, 16'd0);

        // Penalties, 00:25 at TICKS_PER_SEC=1
        drive(3, M_START);
        drive(3, M_PEN);
        chk("d_pen", tm[3], 16'h0015);
        chk("d_pen_s", {13'd0, st[3]}, 16'd1);
        drive(3, M_LOAD);
        chk("d_load", tm[3], 16'h0025);
        chk("d_load_s", {13'd0, st[3]}, 16'd0);
        drive(3, M_START);
        drive(3, M_TICK | M_PEN);
        chk("d_pen_tick", tm[3], 16'h0014);
        @(negedge clk);
        do_ticks(3, 3);
        chk("d_0011", tm[3], 16'h0011);
        chk("d_warn_11", {15'd0, warn_v[3]}, 16'd0);
        do_ticks(3, 1);
        chk("d_0010", tm[3], 16'h0010);
        chk("d_warn_10", {15'd0, warn_v[3]}, 16'd1);
        do_ticks(3, 3);
        chk("d_0007", tm[3], 16'h0007);
        drive(3, M_PEN);
        chk("d_sat", tm[3], 16'h0000);
        chk("d_sat_s", {13'd0, st[3]}, 16'd4);
        chk("d_sat_b", {15'd0, boom_v[3]}, 16'd1);

        // Pause holds time and prescaler (TICKS_PER_SEC=10)
        do_ticks(0, 3);
        chk("a_3ticks", tm[0], 16'h0500);
        drive(0, M_PAUSE);
        chk("a_pause_s", {13'd0, st[0]}, 16'd2);
        do_ticks(0, 20);
        chk("a_paused_t", tm[0], 16'h0500);
        chk("a_paused_s", {13'd0, st[0]}, 16'd2);
        drive(0, M_START);
        chk("a_resume_s", {13'd0, st[0]}, 16'd1);
        do_ticks(0, 6);
        chk("a_9th", tm[0], 16'h0500);
        do_ticks(0, 1);
        chk("a_10th", tm[0], 16'h0459);

        // Reset mid-RUN with a pending tick edge
        tick_v[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick_v[0] = 1'b0;
        chk("a_rst_t", tm[0], 16'h0500);
        chk("a_rst_s", {13'd0, st[0]}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
